// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial/parallel converters.
package s2p_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } s2p_state_e;

  // Number of chunks per word; zero flags an illegal width pairing.
  function automatic int unsigned s2p_count_max(input int unsigned p_width,
                                                input int unsigned s_width);
    return (s_width == 0) ? 0 : p_width / s_width;
  endfunction

  // Width of a counter that runs 0 .. limit-1 (at least one bit).
  function automatic int unsigned s2p_cnt_width(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/s2p_out_buf.sv
// Output holding register with valid/ready handshake and overrun pulse.
module s2p_out_buf #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  assign accept = valid_q && out_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        // Consumer is stalled: keep the old word, drop the new one.
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      data_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = data_q;
  assign out_valid    = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Assembles MSB-first serial chunks into parallel words.
// Optional inter-chunk idle timeout is enabled with macro S2P_TIMEOUT_EN.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int unsigned P_WIDTH        = 24,
  parameter int unsigned S_WIDTH        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_WIDTH-1:0] serial_in,
  input  logic               serial_valid,
  output logic [P_WIDTH-1:0] parallel_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  localparam int unsigned COUNT_MAX = s2p_count_max(P_WIDTH, S_WIDTH);
  localparam int unsigned CNT_W     = s2p_cnt_width(COUNT_MAX);
  // Only the chunks already received need storage; the top chunk is never kept.
  localparam int unsigned HOLD_W    = (COUNT_MAX > 1) ? P_WIDTH - S_WIDTH : 1;

  if (S_WIDTH == 0 || P_WIDTH == 0 || (P_WIDTH % S_WIDTH) != 0) begin : g_bad_width
    $error("P_WIDTH must be a nonzero multiple of S_WIDTH");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  s2p_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_next;
  logic [P_WIDTH-1:0] word;
  logic               complete;
  logic               discard;

  if (COUNT_MAX == 1) begin : g_single
    assign word      = serial_in;
    assign hold_next = '0;
  end else begin : g_multi
    assign word      = {hold_q, serial_in};
    assign hold_next = word[HOLD_W-1:0];
  end

`ifdef S2P_TIMEOUT_EN
  localparam int unsigned TO_W = s2p_cnt_width(TIMEOUT_CYCLES);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout_q;

  assign discard = (state_q == COLLECT) && !serial_valid &&
                   (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if (state_q == COLLECT && !serial_valid && !discard) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= discard;
    end
  end

  assign timeout = timeout_q;
`else
  assign discard = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    complete = 1'b0;
    if (serial_valid) begin
      hold_d = hold_next;
      if (cnt_q == CNT_W'(COUNT_MAX - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = COLLECT;
      end
    end else if (discard) begin
      cnt_d   = '0;
      hold_d  = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign busy = (state_q == COLLECT);

  s2p_out_buf #(
    .WIDTH(P_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (complete),
    .word        (word),
    .out_ready   (out_ready),
    .parallel_out(parallel_out),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: vector table plus scoreboard queue.
module tb_serial_to_parallel;

  localparam int unsigned PW = 24;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] serial_in;
  logic          serial_valid;
  logic [PW-1:0] parallel_out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;
  logic          timeout;

  int compared   = 0;
  int mismatched = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic [SW-1:0] c0;
    logic [SW-1:0] c1;
    logic [SW-1:0] c2;
    int            gap;
    logic [PW-1:0] expw;
  } vec_t;

  vec_t vecs[4];

  serial_to_parallel #(
    .P_WIDTH       (PW),
    .S_WIDTH       (SW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .serial_valid(serial_valid),
    .parallel_out(parallel_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] c);
    serial_in    = c;
    serial_valid = 1'b1;
    tick(1);
    serial_valid = 1'b0;
    serial_in    = '0;
  endtask

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {8'h0, parallel_out}, 32'hDEAD_BEEF);
      end else begin
        check("sb_word", {8'h0, parallel_out}, {8'h0, exp_q.pop_front()});
      end
    end
    if (rst_n && !out_valid && parallel_out != '0) begin
      check("zero_when_invalid", {8'h0, parallel_out}, 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{c0: 8'h12, c1: 8'h34, c2: 8'h56, gap: 0, expw: 24'h123456};
    vecs[1] = '{c0: 8'hFF, c1: 8'h00, c2: 8'hFF, gap: 3, expw: 24'hFF00FF};
    vecs[2] = '{c0: 8'h00, c1: 8'h00, c2: 8'h01, gap: 1, expw: 24'h000001};
    vecs[3] = '{c0: 8'h80, c1: 8'h7F, c2: 8'h01, gap: 5, expw: 24'h807F01};

    rst_n        = 1'b0;
    serial_in    = '0;
    serial_valid = 1'b0;
    out_ready    = 1'b0;
    tick(2);
    check("rst_parallel_out", {8'h0, parallel_out}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Back-to-back chunks, word visible one cycle after the last chunk.
    out_ready = 1'b1;
    send(8'hA1);
    check("busy_after_first", {31'h0, busy}, 32'h1);
    send(8'hB2);
    exp_q.push_back(24'hA1B2C3);
    send(8'hC3);
    check("abc_valid", {31'h0, out_valid}, 32'h1);
    check("abc_word", {8'h0, parallel_out}, 32'h00A1B2C3);
    check("abc_busy_done", {31'h0, busy}, 32'h0);
    tick(1);
    check("abc_valid_one_cycle", {31'h0, out_valid}, 32'h0);

    // Vector table, including the parallel_to_serial loopback stream 12 34 56.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].c0);
      tick(vecs[i].gap);
      check("vec_busy_mid", {31'h0, busy}, 32'h1);
      send(vecs[i].c1);
      tick(vecs[i].gap);
      exp_q.push_back(vecs[i].expw);
      send(vecs[i].c2);
      tick(2);
    end

    // Stalled consumer: second word is dropped with an overrun pulse.
    out_ready = 1'b0;
    exp_q.push_back(24'h010203);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h05);
    check("ovr_quiet_before", {31'h0, overrun}, 32'h0);
    send(8'h06);
    check("ovr_pulse", {31'h0, overrun}, 32'h1);
    check("ovr_keep_old", {8'h0, parallel_out}, 32'h00010203);
    tick(1);
    check("ovr_pulse_end", {31'h0, overrun}, 32'h0);
    check("ovr_still_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;

    // Completion in the same cycle the old word is accepted: no bubble.
    exp_q.push_back(24'h070809);
    send(8'h07);
    send(8'h08);
    send(8'h09);
    send(8'h0A);
    send(8'h0B);
    out_ready = 1'b1;
    exp_q.push_back(24'h0A0B0C);
    send(8'h0C);
    check("nobubble_valid", {31'h0, out_valid}, 32'h1);
    check("nobubble_word", {8'h0, parallel_out}, 32'h000A0B0C);
    check("nobubble_no_ovr", {31'h0, overrun}, 32'h0);
    tick(2);

    // Reset mid-word discards the partial word.
    send(8'h01);
    send(8'h02);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_word", {8'h0, parallel_out}, 32'h0);
    check("midrst_flags", {30'h0, overrun, timeout}, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    exp_q.push_back(24'h010203);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    tick(2);

`ifdef S2P_TIMEOUT_EN
    send(8'h11);
    send(8'h22);
    tick(15);
    check("to_not_yet", {31'h0, timeout}, 32'h0);
    check("to_busy_before", {31'h0, busy}, 32'h1);
    tick(1);
    check("to_pulse", {31'h0, timeout}, 32'h1);
    check("to_busy_cleared", {31'h0, busy}, 32'h0);
    tick(1);
    check("to_pulse_end", {31'h0, timeout}, 32'h0);
    exp_q.push_back(24'hDDEEFF);
    send(8'hDD);
    send(8'hEE);
    send(8'hFF);
    tick(2);
`else
    send(8'h11);
    send(8'h22);
    tick(40);
    check("gap_no_timeout", {31'h0, timeout}, 32'h0);
    check("gap_still_busy", {31'h0, busy}, 32'h1);
    exp_q.push_back(24'h112233);
    send(8'h33);
    tick(2);
`endif

    tick(3);
    check("sb_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
